// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide sequencer.
// Operation decode, FSM states and sign-handling utilities live here.
package mdu_pkg;

    localparam int XLEN     = 32;
    localparam int MDU_ITER = 32;
    localparam logic [4:0] CNT_LAST = 5'(MDU_ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mdu_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } mdu_mode_e;

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [XLEN-1:0] neg_if(
        input logic [XLEN-1:0] v,
        input logic            n
    );
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath: shift-add for multiply,
// shift-subtract-restore for divide, over a 64-bit accumulator.
module mdu_iter_step
    import mdu_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              bit_in,
    input  mdu_mode_e         mode,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part;
    logic [XLEN:0] diff;

    // Multiply: high half accumulates, product shifts right into low half.
    // Divide: high half is the partial remainder, quotient bits shift in low.
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]}
                 + {1'b0, operand & {XLEN{bit_in}}};
        part     = {acc[2*XLEN-1:XLEN], bit_in};
        diff     = part - {1'b0, operand};
        acc_next = {sum, acc[XLEN-1:1]};
        if (mode == MODE_DIV) begin
            if (diff[XLEN]) begin
                acc_next = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/execute_mdu_sequencer.sv
// Execute-stage RV32M sequencer: FSM, iteration counter, sign fix-up and
// pipeline stall/valid generation around the shared iteration datapath.
module execute_mdu_sequencer
    import mdu_pkg::*;
(
    input  logic            i_execute_clk,
    input  logic            i_execute_reset,
    input  logic            i_mdu_start,
    input  logic [2:0]      i_mdu_funct3,
    input  logic [XLEN-1:0] i_mdu_rs1_data,
    input  logic [XLEN-1:0] i_mdu_rs2_data,
    input  logic            i_flush,
    output logic            o_mdu_stall,
    output logic            o_mdu_busy,
    output logic            o_mdu_valid,
    output logic [XLEN-1:0] o_mdu_result
);

    mdu_state_e        state_q, state_d;
    mdu_op_e           op_q, op_in;
    mdu_mode_e         mode;
    logic              sign_a_q, sign_b_q;
    logic              sign_a_in, sign_b_in;
    logic [XLEN-1:0]   mag_a_q, mag_b_q;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [2*XLEN-1:0] prod;
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   special_res, fix_res;
    logic [XLEN-1:0]   step_operand;
    logic              step_bit;
    logic              div_zero, div_ovf;
    logic              latch;
    logic              busy_q, valid_q;

    assign op_in     = mdu_op_e'(i_mdu_funct3);
    assign sign_a_in = is_signed_a(op_in) & i_mdu_rs1_data[XLEN-1];
    assign sign_b_in = is_signed_b(op_in) & i_mdu_rs2_data[XLEN-1];
    assign mag_a_in  = neg_if(i_mdu_rs1_data, sign_a_in);
    assign mag_b_in  = neg_if(i_mdu_rs2_data, sign_b_in);

    assign div_zero = is_div(op_in) && (i_mdu_rs2_data == '0);
    assign div_ovf  = is_div(op_in) && is_signed_b(op_in)
                   && (i_mdu_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (i_mdu_rs2_data == '1);

    always_comb begin
        special_res = '0;
        unique case (1'b1)
            div_zero && is_rem(op_in):  special_res = i_mdu_rs1_data;
            div_zero && !is_rem(op_in): special_res = '1;
            !div_zero && !is_rem(op_in):
                special_res = {1'b1, {(XLEN-1){1'b0}}};
            default:                    special_res = '0;
        endcase
    end

    // Divide walks the dividend MSB-first; multiply walks the multiplier LSB-first.
    assign mode         = is_div(op_q) ? MODE_DIV : MODE_MUL;
    assign step_operand = is_div(op_q) ? mag_b_q : mag_a_q;
    assign step_bit     = is_div(op_q) ? mag_a_q[~cnt_q] : mag_b_q[cnt_q];

    mdu_iter_step u_step (
        .acc      (acc_step_in()),
        .operand  (step_operand),
        .bit_in   (step_bit),
        .mode     (mode),
        .acc_next (acc_step)
    );

    function automatic logic [2*XLEN-1:0] acc_step_in();
        return acc_q;
    endfunction

    assign prod = (sign_a_q ^ sign_b_q) ? (~acc_step + 1'b1) : acc_step;

    always_comb begin
        fix_res = '0;
        unique case (op_q)
            OP_MUL:    fix_res = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   fix_res = neg_if(acc_step[XLEN-1:0],
                                        sign_a_q ^ sign_b_q);
            OP_REM,
            OP_REMU:   fix_res = neg_if(acc_step[2*XLEN-1:XLEN],
                                        sign_a_q);
            default:   fix_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        latch    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_mdu_start) begin
                    latch = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = fix_res;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Squash wins over everything but reset and leaves the result intact.
        if (i_flush) begin
            state_d  = IDLE;
            acc_d    = acc_q;
            cnt_d    = cnt_q;
            result_d = result_q;
            latch    = 1'b0;
        end
    end

    always_ff @(posedge i_execute_clk or posedge i_execute_reset) begin
        if (i_execute_reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= (state_d != IDLE);
            valid_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge i_execute_clk or posedge i_execute_reset) begin
        if (i_execute_reset) begin
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
        end else if (latch) begin
            op_q     <= op_in;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            mag_a_q  <= mag_a_in;
            mag_b_q  <= mag_b_in;
        end
    end

    assign o_mdu_stall = ~i_execute_reset & ~i_flush &
                         (((state_q == IDLE) & i_mdu_start) |
                          (state_q == BUSY));
    assign o_mdu_busy   = busy_q;
    assign o_mdu_valid  = valid_q;
    assign o_mdu_result = result_q;

endmodule

// File: doc/execute_mdu_sequencer.md
# execute_mdu_sequencer

Iterative RV32M multiply/divide sequencer for the execute stage. Accepts one M-extension operation per start, runs a 32-step shift-add or restoring-divide loop over one shared 64-bit datapath, and stalls IF/ID/EX until the result is ready. The result is muxed into the EX→MEM ALU data path in the DONE cycle. A flush aborts the operation.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- i_execute_clk  in  1  clock.
- i_execute_reset  in  1  reset; asynchronous, active-high.
- i_mdu_start  in  1  the EX-stage instruction is an M-op; level signal, held while stalled.
- i_mdu_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_mdu_rs1_data  in  32  post-forwarding operand A.
- i_mdu_rs2_data  in  32  post-forwarding operand B.
- i_flush  in  1  squash from MEM; highest priority after reset.
- o_mdu_stall  out  1  hold PC, IF/ID and ID/EX registers.
- o_mdu_busy  out  1  state != IDLE.
- o_mdu_valid  out  1  o_mdu_result is valid this cycle.
- o_mdu_result  out  32  final result; registered.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE with start=1 and flush=0:
  - latch funct3, the operand sign flags and the operand magnitudes (two's-complement abs).
  - Signedness: rs1 is signed for MULH, MULHSU, DIV and REM; rs2 is signed for MULH, DIV and REM.
  - Clear the 64-bit accumulator and the 5-bit counter.
- Special cases skip BUSY and go IDLE→DONE:
  - divide by zero: quotient 0xFFFFFFFF, remainder = rs1.
  - signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- All other starts go IDLE→BUSY.
- BUSY, multiply: each cycle adds the multiplicand to the accumulator if multiplier bit[cnt] is set, then shifts.
- BUSY, divide: each cycle performs one restoring step (shift remainder, subtract, set quotient bit).
- BUSY exits to DONE when cnt==31; the counter increments modulo 32.
- Sign fix-up on BUSY exit:
  - negate the product if signA^signB.
  - quotient sign is signA^signB; remainder sign is signA.
  - Write the result register: MUL = low word, MULH* = high word.
- DONE: o_mdu_valid=1 and stall=0, so the pipeline advances and EX captures the result. The still-high start is ignored. Next state is IDLE.
- o_mdu_stall = (IDLE & start & !flush) | BUSY, forced to 0 when i_flush=1.
- Flush in any state: next state IDLE, no valid pulse, result register unchanged.
- Operands are captured only in IDLE, so forwarding changes during the stall have no effect.

## Timing
- Reset values: state IDLE, counter 0, accumulator 0, o_mdu_result 0, o_mdu_valid 0, o_mdu_stall 0, o_mdu_busy 0.
- Reset mid-operation returns to IDLE asynchronously; no valid pulse is produced.
- Normal op:
  - start sampled at edge 0, BUSY for 32 cycles, DONE in cycle 33.
  - stall is high for cycles 0..32 (33 cycles) and low in cycle 33.
- Special-case op: stall high in cycle 0 only; DONE/valid in cycle 1.
- Back-to-back: a start in the cycle after DONE is accepted; minimum spacing is 34 cycles for normal ops.
- o_mdu_stall is combinational from start/flush/state. All other outputs are registered.

## Structure
- mdu_pkg holds:
  - typedef enum mdu_state_e {IDLE, BUSY, DONE}.
  - typedef enum mdu_op_e covering the 8 funct3 codes.
  - localparam MDU_ITER = 32.
  - helper functions is_div(op) and is_signed_a/b(op).
- One sub-module, mdu_iter_step: combinational single-iteration datapath for the add-shift or subtract-restore step. Inputs: accumulator, operand, mode. Output: next accumulator.
- The top module holds the FSM, counter, sign fix-up and stall/valid logic.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; valid in cycle 33; stall high exactly 33 cycles.
- High-word multiplies:
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - All complete with valid in cycle 1 and stall high for 1 cycle.
- Flush:
  - flush in BUSY cycle 10 → stall 0 that cycle, IDLE next, no valid.
  - a new DIVU 9/3 started the following cycle → 3 in cycle 33.
- Async reset asserted mid-BUSY → all outputs 0 immediately. After release, start is accepted and MUL 3×4 → 12.
